// File: rtl/cpu_seq_if.sv
// Memory bus between the cpu_seq sequencer and its 32 x 8 memory.
//   a_bus : 5-bit memory address, driven by the sequencer
//   wdata : 8-bit write data (the accumulator), driven by the sequencer
//   we    : write strobe; memory captures wdata at the tclk edge ending the cycle
//   rdata : 8-bit read data for the current a_bus, combinational from memory
// master = sequencer side, slave = memory side.
interface cpu_seq_if;
    logic [4:0] a_bus;
    logic [7:0] wdata;
    logic       we;
    logic [7:0] rdata;

    modport master (output a_bus, output wdata, output we, input rdata);
    modport slave  (input a_bus, input wdata, input we, output rdata);
endinterface

// File: rtl/cpu_seq.sv
// cpu_seq: four-state accumulator-machine sequencer (FETCH, DECODE, EXEC_A,
// EXEC_B). Each instruction takes exactly four tclk cycles. IR[7:5] is the
// opcode and IR[4:0] the operand address.
// Ports:
//   tclk        : system clock, all state updates on its rising edge
//   rst_n       : asynchronous active-low reset
//   run         : level enable; when low the machine parks in FETCH
//   mem         : memory bus (a_bus, wdata, we out; rdata in)
//   instruction : instruction register
//   state       : current cycle state, FETCH=00 DECODE=01 EXEC_A=10 EXEC_B=11
//   acc         : accumulator
//   zero        : acc == 0
//   halted      : sticky after HLT, cleared only by reset
module cpu_seq #(
    parameter logic [4:0] RESET_PC = 5'd0
) (
    input  logic             tclk,
    input  logic             rst_n,
    input  logic             run,
    cpu_seq_if.master        mem,
    output logic [7:0]       instruction,
    output logic [1:0]       state,
    output logic [7:0]       acc,
    output logic             zero,
    output logic             halted
);

    typedef enum logic [1:0] {
        FETCH  = 2'b00,
        DECODE = 2'b01,
        EXEC_A = 2'b10,
        EXEC_B = 2'b11
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_HLT  = 3'b001,
        OP_NAND = 3'b010,
        OP_ST   = 3'b100,
        OP_LD   = 3'b101,
        OP_JPNZ = 3'b111
    } opcode_t;

    state_t     cur_state;
    state_t     next_state;
    logic [4:0] pc;
    logic [4:0] a_bus_c;
    logic       we_c;
    logic       fetch_go;
    opcode_t    op;
    logic [4:0] adr;

    assign op       = opcode_t'(instruction[7:5]);
    assign adr      = instruction[4:0];
    // A halted machine never leaves FETCH, which is what freezes IR, PC and acc.
    assign fetch_go = run && !halted;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge tclk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= FETCH;
        end else begin
            cur_state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default first so that no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        next_state = cur_state;
        a_bus_c    = pc;
        we_c       = 1'b0;
        case (cur_state)
            FETCH: begin
                if (fetch_go) begin
                    next_state = DECODE;
                end
            end
            DECODE: begin
                next_state = EXEC_A;
            end
            EXEC_A: begin
                next_state = EXEC_B;
                a_bus_c    = adr;
            end
            EXEC_B: begin
                next_state = FETCH;
                a_bus_c    = adr;
                // Decoded from the asynchronously reset state, so a reset
                // during EXEC_B drops the strobe immediately.
                we_c       = (op == OP_ST);
            end
            default: begin
                next_state = FETCH;
            end
        endcase
    end

    always_ff @(posedge tclk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            instruction <= 8'h00;
            acc         <= 8'h00;
            halted      <= 1'b0;
        end else begin
            case (cur_state)
                FETCH: begin
                    if (fetch_go) begin
                        instruction <= mem.rdata;
                    end
                end
                DECODE: begin
                    pc <= pc + 5'd1;
                end
                EXEC_B: begin
                    case (op)
                        OP_ADD:  acc <= acc + mem.rdata;
                        OP_NAND: acc <= ~(acc & mem.rdata);
                        OP_LD:   acc <= mem.rdata;
                        // A taken jump replaces the increment done in DECODE.
                        OP_JPNZ: if (acc != 8'h00) pc <= adr;
                        OP_HLT:  halted <= 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign mem.a_bus = a_bus_c;
    assign mem.we    = we_c;
    assign mem.wdata = acc;
    assign state     = cur_state;
    assign zero      = (acc == 8'h00);

endmodule

// File: tb/tb_cpu_seq.sv
// Testbench for cpu_seq. A behavioural instruction model pushes the expected
// per-cycle observation (state, a_bus, acc, wdata, we) onto a scoreboard
// queue as each program is set up; each scenario task pops and compares one
// entry per cycle, sampled on the falling edge, plus fixed-value spot checks.
module tb_cpu_seq;

    localparam logic [1:0] S_FETCH  = 2'b00;
    localparam logic [1:0] S_DECODE = 2'b01;
    localparam logic [1:0] S_EXEC_A = 2'b10;
    localparam logic [1:0] S_EXEC_B = 2'b11;

    typedef struct packed {
        logic [1:0] st;
        logic [4:0] a;
        logic [7:0] acc;
        logic [7:0] wd;
        logic       we;
    } obs_t;

    logic       tclk  = 1'b0;
    logic       rst_n = 1'b1;
    logic       run   = 1'b0;
    logic [7:0] instruction;
    logic [1:0] state;
    logic [7:0] acc;
    logic       zero;
    logic       halted;

    cpu_seq_if bus ();

    cpu_seq dut (
        .tclk        (tclk),
        .rst_n       (rst_n),
        .run         (run),
        .mem         (bus),
        .instruction (instruction),
        .state       (state),
        .acc         (acc),
        .zero        (zero),
        .halted      (halted)
    );

    always #5 tclk = ~tclk;

    // NOTE: the memory array has no reset; each scenario clears and reloads
    // it explicitly so no test depends on leftovers from the previous one.
    logic [7:0] mem [32];
    int         wr_count = 0;

    assign bus.rdata = mem[bus.a_bus];

    always @(posedge tclk) begin
        if (bus.we === 1'b1) begin
            mem[bus.a_bus] = bus.wdata;
            wr_count++;
        end
    end

    int   checks   = 0;
    int   failures = 0;
    obs_t sb [$];

    // Reference model state
    logic [4:0] m_pc;
    logic [7:0] m_acc;
    logic [7:0] m_mem [32];

    function automatic obs_t mk(logic [1:0] st, logic [4:0] a, logic [7:0] ac, logic w);
        obs_t o;
        o.st  = st;
        o.a   = a;
        o.acc = ac;
        o.wd  = ac;
        o.we  = w;
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.st  = state;
        o.a   = bus.a_bus;
        o.acc = acc;
        o.wd  = bus.wdata;
        o.we  = bus.we;
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("st=%0d a=%0d acc=%h wd=%h we=%b", o.st, o.a, o.acc, o.wd, o.we);
    endfunction

    task automatic model_init();
        m_pc  = 5'd0;
        m_acc = 8'h00;
        for (int i = 0; i < 32; i++) m_mem[i] = mem[i];
    endtask

    // Push the four cycles of the instruction at m_pc, then execute it.
    task automatic model_instr();
        logic [7:0] ir;
        logic [2:0] op;
        logic [4:0] adr;
        ir  = m_mem[m_pc];
        op  = ir[7:5];
        adr = ir[4:0];
        sb.push_back(mk(S_FETCH,  m_pc, m_acc, 1'b0));
        sb.push_back(mk(S_DECODE, m_pc, m_acc, 1'b0));
        sb.push_back(mk(S_EXEC_A, adr,  m_acc, 1'b0));
        sb.push_back(mk(S_EXEC_B, adr,  m_acc, op == 3'b100));
        m_pc = m_pc + 5'd1;
        case (op)
            3'b000: m_acc = m_acc + m_mem[adr];
            3'b010: m_acc = ~(m_acc & m_mem[adr]);
            3'b101: m_acc = m_mem[adr];
            3'b100: m_mem[adr] = m_acc;
            3'b111: if (m_acc != 8'h00) m_pc = adr;
            default: ;
        endcase
    endtask

    task automatic model_hold(input int n);
        for (int i = 0; i < n; i++) sb.push_back(mk(S_FETCH, m_pc, m_acc, 1'b0));
    endtask

    // Leaves the bench at a falling edge, out of reset, run=0, memory cleared.
    task automatic do_reset();
        @(negedge tclk);
        run   = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        @(negedge tclk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        rst_n = 1'b0;
        run   = 1'b1;
        for (int i = 0; i < 32; i++) mem[i] = 8'hA5;
        #2;
        checks++;
        if ({state, acc, instruction, halted, bus.we, zero, bus.a_bus} !== {S_FETCH, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0}) begin
            failures++;
            $display("FAIL reset_async st=%0d acc=%h ir=%h halted=%b we=%b zero=%b a=%0d want st=0 acc=00 ir=00 halted=0 we=0 zero=1 a=0",
                     state, acc, instruction, halted, bus.we, zero, bus.a_bus);
        end
        @(posedge tclk);
        #1;
        checks++;
        if (state !== S_FETCH || instruction !== 8'h00) begin
            failures++;
            $display("FAIL reset_hold st=%0d ir=%h want st=0 ir=00", state, instruction);
        end
        @(negedge tclk);
        run   = 1'b0;
        rst_n = 1'b1;
    endtask

    // LD 5; run dropped during DECODE, the instruction still completes.
    task automatic test_ld();
        obs_t o, e;
        do_reset();
        mem[0] = 8'hA5;
        mem[5] = 8'h03;
        model_init();
        model_instr();
        model_hold(2);
        run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL ld_trace[%0d] got %s want %s", i, fmt(o), fmt(e));
            end
            if (i == 1) run = 1'b0;
            @(negedge tclk);
        end
        checks++;
        if (acc !== 8'h03 || instruction !== 8'hA5 || zero !== 1'b0 || bus.a_bus !== 5'd1) begin
            failures++;
            $display("FAIL ld_result acc=%h ir=%h zero=%b a=%0d want acc=03 ir=a5 zero=0 a=1",
                     acc, instruction, zero, bus.a_bus);
        end
    endtask

    // LD FF, ADD 02 (wraps to 01), NAND FE (-> FF), NAND FF (-> 00).
    task automatic test_alu();
        obs_t o, e;
        do_reset();
        mem[0]  = 8'hAA;
        mem[1]  = 8'h0B;
        mem[2]  = 8'h4C;
        mem[3]  = 8'h4D;
        mem[10] = 8'hFF;
        mem[11] = 8'h02;
        mem[12] = 8'hFE;
        mem[13] = 8'hFF;
        model_init();
        repeat (4) model_instr();
        model_hold(1);
        run = 1'b1;
        for (int i = 0; i < 17; i++) begin
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL alu_trace[%0d] got %s want %s", i, fmt(o), fmt(e));
            end
            if (i == 8) begin
                checks++;
                if (acc !== 8'h01 || zero !== 1'b0) begin
                    failures++;
                    $display("FAIL add_wrap acc=%h zero=%b want acc=01 zero=0", acc, zero);
                end
            end
            if (i == 15) run = 1'b0;
            @(negedge tclk);
        end
        checks++;
        if (acc !== 8'h00 || zero !== 1'b1) begin
            failures++;
            $display("FAIL nand_zero acc=%h zero=%b want acc=00 zero=1", acc, zero);
        end
    endtask

    // JPNZ taken to 7, not taken at 8, taken to 30, not taken at 31 (wrap to 0).
    task automatic test_jpnz();
        obs_t o, e;
        do_reset();
        mem[0]  = 8'hB4;
        mem[1]  = 8'hE7;
        mem[7]  = 8'hB5;
        mem[8]  = 8'hE7;
        mem[9]  = 8'hB6;
        mem[10] = 8'hFE;
        mem[30] = 8'hB5;
        mem[31] = 8'hE7;
        mem[20] = 8'h01;
        mem[21] = 8'h00;
        mem[22] = 8'h01;
        model_init();
        repeat (8) model_instr();
        model_hold(1);
        run = 1'b1;
        for (int i = 0; i < 33; i++) begin
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL jpnz_trace[%0d] got %s want %s", i, fmt(o), fmt(e));
            end
            if (i == 8) begin
                checks++;
                if (bus.a_bus !== 5'd7) begin
                    failures++;
                    $display("FAIL jpnz_taken a=%0d want 7", bus.a_bus);
                end
            end
            if (i == 16) begin
                checks++;
                if (bus.a_bus !== 5'd9) begin
                    failures++;
                    $display("FAIL jpnz_not_taken a=%0d want 9", bus.a_bus);
                end
            end
            if (i == 31) run = 1'b0;
            @(negedge tclk);
        end
        checks++;
        if (bus.a_bus !== 5'd0 || state !== S_FETCH) begin
            failures++;
            $display("FAIL jpnz_pc_wrap a=%0d st=%0d want a=0 st=0", bus.a_bus, state);
        end
    endtask

    // LD 5A, ST 31: one write strobe, at address 31, carrying 5A.
    task automatic test_store();
        obs_t o, e;
        int   wr0;
        do_reset();
        mem[0]  = 8'hB4;
        mem[1]  = 8'h9F;
        mem[20] = 8'h5A;
        model_init();
        repeat (2) model_instr();
        model_hold(1);
        wr0 = wr_count;
        run = 1'b1;
        for (int i = 0; i < 9; i++) begin
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL st_trace[%0d] got %s want %s", i, fmt(o), fmt(e));
            end
            if (i == 7) begin
                checks++;
                if (bus.we !== 1'b1 || bus.a_bus !== 5'd31 || bus.wdata !== 8'h5A) begin
                    failures++;
                    $display("FAIL st_strobe we=%b a=%0d wdata=%h want we=1 a=31 wdata=5a",
                             bus.we, bus.a_bus, bus.wdata);
                end
                run = 1'b0;
            end
            @(negedge tclk);
        end
        checks++;
        if (wr_count - wr0 !== 1 || mem[31] !== 8'h5A) begin
            failures++;
            $display("FAIL st_memory writes=%0d mem31=%h want writes=1 mem31=5a", wr_count - wr0, mem[31]);
        end
    endtask

    // LD 3C, HLT, then run toggled for 10 cycles: everything frozen.
    task automatic test_halt();
        obs_t o, e;
        do_reset();
        mem[0]  = 8'hB4;
        mem[1]  = 8'h20;
        mem[2]  = 8'hA0;
        mem[20] = 8'h3C;
        model_init();
        repeat (2) model_instr();
        model_hold(10);
        run = 1'b1;
        for (int i = 0; i < 18; i++) begin
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL halt_trace[%0d] got %s want %s", i, fmt(o), fmt(e));
            end
            if (i >= 8) run = ~run;
            @(negedge tclk);
        end
        checks++;
        if ({halted, state, acc, bus.a_bus, bus.we, instruction} !== {1'b1, S_FETCH, 8'h3C, 5'd2, 1'b0, 8'h20}) begin
            failures++;
            $display("FAIL halt_frozen halted=%b st=%0d acc=%h a=%0d we=%b ir=%h want halted=1 st=0 acc=3c a=2 we=0 ir=20",
                     halted, state, acc, bus.a_bus, bus.we, instruction);
        end
        run = 1'b0;
    endtask

    // Reset pulsed during EXEC_B of ST 25: strobe drops at once, no write.
    task automatic test_reset_mid_store();
        obs_t o, e;
        int   wr0;
        do_reset();
        mem[0]  = 8'hB4;
        mem[1]  = 8'h99;
        mem[20] = 8'h77;
        mem[25] = 8'h11;
        model_init();
        repeat (2) model_instr();
        wr0 = wr_count;
        run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            e = sb.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL rst_st_trace[%0d] got %s want %s", i, fmt(o), fmt(e));
            end
            if (i < 7) @(negedge tclk);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.we, state, acc, instruction, halted, zero, bus.a_bus} !== {1'b0, S_FETCH, 8'h00, 8'h00, 1'b0, 1'b1, 5'd0}) begin
            failures++;
            $display("FAIL rst_mid_st we=%b st=%0d acc=%h ir=%h halted=%b zero=%b a=%0d want we=0 st=0 acc=00 ir=00 halted=0 zero=1 a=0",
                     bus.we, state, acc, instruction, halted, zero, bus.a_bus);
        end
        @(negedge tclk);
        run   = 1'b0;
        rst_n = 1'b1;
        checks++;
        if (wr_count !== wr0 || mem[25] !== 8'h11) begin
            failures++;
            $display("FAIL rst_no_write writes=%0d mem25=%h want writes=%0d mem25=11", wr_count, mem[25], wr0);
        end
    endtask

    initial begin
        test_reset();
        test_ld();
        test_alu();
        test_jpnz();
        test_store();
        test_halt();
        test_reset_mid_store();
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
